// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the configuration-chain loader: FSM states, error codes
// and the word-count helper used to size the load phase.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE         = 2'b00;
  localparam logic [1:0] ERR_NO_ECHO      = 2'b01;
  localparam logic [1:0] ERR_LEN_MISMATCH = 2'b10;

  function automatic int words_for(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word buffer and bit serializer for the load phase: accepts cfg words, emits
// them LSB first and reports when the last chain bit has been shifted.
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(2*CHAIN_LEN+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              active,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              bit_out,
  output logic              shift,
  output logic              last_shift
);

  localparam int NWORDS    = words_for(CHAIN_LEN, WORD_W);
  localparam int TAIL_BITS = CHAIN_LEN % WORD_W;
  localparam int BC_W      = $clog2(WORD_W+1);
  localparam logic [BC_W-1:0] FULL_CNT = BC_W'(WORD_W);
  localparam logic [BC_W-1:0] TAIL_CNT = BC_W'((TAIL_BITS == 0) ? WORD_W : TAIL_BITS);

  logic [WORD_W-1:0] word_buf;
  logic [BC_W-1:0]   buf_cnt;
  logic [CNT_W-1:0]  words_in;
  logic [CNT_W-1:0]  bits_out;
  logic              words_left;
  logic              last_word;
  logic              take;

  assign words_left = (words_in != CNT_W'(NWORDS));
  assign last_word  = (words_in == CNT_W'(NWORDS-1));
  // Refill while the final buffered bit is still going out, so words stream with no bubble.
  assign cfg_ready  = active && words_left && (buf_cnt <= BC_W'(1));
  assign take       = cfg_valid && cfg_ready;
  assign shift      = active && (buf_cnt != '0);
  assign last_shift = shift && (bits_out == CNT_W'(CHAIN_LEN-1));
  assign bit_out    = word_buf[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_cnt  <= '0;
      words_in <= '0;
      bits_out <= '0;
    end else if (clear) begin
      buf_cnt  <= '0;
      words_in <= '0;
      bits_out <= '0;
    end else begin
      // Only the valid low bits of a short final word are counted; the rest never shift.
      if (take) begin
        buf_cnt  <= last_word ? TAIL_CNT : FULL_CNT;
        words_in <= words_in + CNT_W'(1);
      end else if (shift) begin
        buf_cnt  <= buf_cnt - BC_W'(1);
      end
      if (shift) begin
        bits_out <= bits_out + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      word_buf <= cfg_data;
    end else if (shift) begin
      word_buf <= word_buf >> 1;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: probes the loop-back chain length, then serially
// loads the bitstream and releases IO isolation on a clean load.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(2*CHAIN_LEN+1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              shift_en,
  output logic              isol_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  measured_len
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] len_nxt;
  logic             error_nxt;
  logic [1:0]       code_nxt;
  logic             ser_clear;
  logic             ser_bit;
  logic             ser_shift;
  logic             ser_last;

  ccff_word_serializer #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W),
    .CNT_W     (CNT_W)
  ) u_ser (
    .clk        (prog_clk),
    .rst        (prog_reset),
    .clear      (ser_clear),
    .active     (state == LOAD),
    .cfg_data   (cfg_data),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .bit_out    (ser_bit),
    .shift      (ser_shift),
    .last_shift (ser_last)
  );

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state        <= IDLE;
      cnt          <= '0;
      error        <= 1'b0;
      err_code     <= ERR_NONE;
      measured_len <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      error        <= error_nxt;
      err_code     <= code_nxt;
      measured_len <= len_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    error_nxt = error;
    code_nxt  = err_code;
    len_nxt   = measured_len;
    ser_clear = 1'b0;
    ccff_head = 1'b0;
    shift_en  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    isol_n    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (state == DONE) begin
          done   = 1'b1;
          isol_n = !error;
        end
        if (start) begin
          state_nxt = PROBE;
          cnt_nxt   = '0;
          error_nxt = 1'b0;
          code_nxt  = ERR_NONE;
          len_nxt   = '0;
          ser_clear = 1'b1;
        end
      end
      PROBE: begin
        // A single 1 is injected on the first cycle; its return time is the chain length.
        busy      = 1'b1;
        shift_en  = 1'b1;
        ccff_head = (cnt == '0);
        cnt_nxt   = cnt + CNT_W'(1);
        if (ccff_tail) begin
          len_nxt = cnt;
          if (cnt == CNT_W'(CHAIN_LEN)) begin
            state_nxt = LOAD;
          end else begin
            state_nxt = DONE;
            error_nxt = 1'b1;
            code_nxt  = ERR_LEN_MISMATCH;
          end
        end else if (cnt == CNT_W'(2*CHAIN_LEN)) begin
          state_nxt = DONE;
          error_nxt = 1'b1;
          code_nxt  = ERR_NO_ECHO;
        end
      end
      LOAD: begin
        busy      = 1'b1;
        shift_en  = ser_shift;
        ccff_head = ser_bit;
        if (ser_last) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
